// File: rtl/hex_display_pkg.sv
// Shared constants and types for the four-digit seven-segment scanner.
// Segment vectors are {g,f,e,d,c,b,a}, active-low.
package hex_display_pkg;

    typedef logic [1:0] digit_t;

    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_A    = 7'b0001000;
    localparam logic [6:0] SEG_B    = 7'b0000011;
    localparam logic [6:0] SEG_C    = 7'b1000110;
    localparam logic [6:0] SEG_D    = 7'b0100001;
    localparam logic [6:0] SEG_E    = 7'b0000110;
    localparam logic [6:0] SEG_F    = 7'b0001110;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

endpackage

// File: rtl/seg7_decoder.sv
// Combinational nibble-to-segment decoder; dash overrides the nibble.
module seg7_decoder
    import hex_display_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dash,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        if (dash) begin
            seg = SEG_DASH;
        end else begin
            unique case (nibble)
                4'h0: seg = SEG_0;
                4'h1: seg = SEG_1;
                4'h2: seg = SEG_2;
                4'h3: seg = SEG_3;
                4'h4: seg = SEG_4;
                4'h5: seg = SEG_5;
                4'h6: seg = SEG_6;
                4'h7: seg = SEG_7;
                4'h8: seg = SEG_8;
                4'h9: seg = SEG_9;
                4'hA: seg = SEG_A;
                4'hB: seg = SEG_B;
                4'hC: seg = SEG_C;
                4'hD: seg = SEG_D;
                4'hE: seg = SEG_E;
                4'hF: seg = SEG_F;
            endcase
        end
    end

endmodule

// File: rtl/hex_display_mux.sv
// Time-multiplexed 4-digit display of BRAM address (left) and data (right),
// with a per-scan snapshot so a full scan never mixes old and new values.
module hex_display_mux
    import hex_display_pkg::*;
#(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] addr,
    input  logic [7:0] rd_data,
    input  logic       write_mode,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);

    logic [CW-1:0] cnt;
    digit_t        digit;
    logic [7:0]    shadow_addr;
    logic [7:0]    shadow_data;
    logic          shadow_wm;

    logic [3:0]    nibble;
    logic          dash;
    logic          blank;
    logic [6:0]    seg_dec;
    logic [3:0]    an_next;
    logic          dp_next;

    // Shadows load on the same edge the index returns to digit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            digit       <= '0;
            shadow_addr <= '0;
            shadow_data <= '0;
            shadow_wm   <= 1'b0;
        end else if (cnt == CNT_LAST) begin
            cnt   <= '0;
            digit <= digit + 2'd1;
            if (digit == 2'd3) begin
                shadow_addr <= addr;
                shadow_data <= rd_data;
                shadow_wm   <= write_mode;
            end
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        nibble = '0;
        dash   = 1'b0;
        unique case (digit)
            2'd0: begin nibble = shadow_data[3:0]; dash = shadow_wm; end
            2'd1: begin nibble = shadow_data[7:4]; dash = shadow_wm; end
            2'd2: nibble = shadow_addr[3:0];
            2'd3: nibble = shadow_addr[7:4];
        endcase
        blank   = (cnt < CNT_BLANK);
        an_next = blank ? '1 : ~(4'b0001 << digit);
        dp_next = !(!blank && digit == 2'd2);
    end

    seg7_decoder u_dec (
        .nibble (nibble),
        .dash   (dash),
        .seg    (seg_dec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an  <= '1;
            seg <= SEG_OFF;
            dp  <= 1'b1;
        end else begin
            an  <= an_next;
            seg <= seg_dec;
            dp  <= dp_next;
        end
    end

endmodule

// File: tb/tb_hex_display_mux.sv
// Directed self-checking bench for hex_display_mux with REFRESH_DIV=4, BLANK_CYCLES=1.
module tb_hex_display_mux;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] addr;
    logic [7:0] rd_data;
    logic       write_mode;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int unsigned n_tests  = 0;
    int unsigned n_failed = 0;

    always #5 clk = ~clk;

    hex_display_mux #(
        .REFRESH_DIV  (4),
        .BLANK_CYCLES (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .addr       (addr),
        .rd_data    (rd_data),
        .write_mode (write_mode),
        .an         (an),
        .seg        (seg),
        .dp         (dp)
    );

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_failed++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    // One full 16-cycle scan starting at slot 0 of digit 0; optional rd_data change mid digit 1.
    task automatic run_scan(input string tag,
                            input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3,
                            input logic chg, input logic [7:0] chg_data);
        logic [6:0] exp_seg [4];
        logic [3:0] exp_an;
        exp_seg[0] = s0; exp_seg[1] = s1; exp_seg[2] = s2; exp_seg[3] = s3;
        for (int d = 0; d < 4; d++) begin
            for (int s = 0; s < 4; s++) begin
                @(posedge clk); #1;
                exp_an = (s == 0) ? 4'b1111 : ~(4'b0001 << d);
                check_eq($sformatf("%s_an_d%0d_s%0d", tag, d, s), {4'b0, an}, {4'b0, exp_an});
                if (s != 0)
                    check_eq($sformatf("%s_seg_d%0d_s%0d", tag, d, s), {1'b0, seg}, {1'b0, exp_seg[d]});
                check_eq($sformatf("%s_dp_d%0d_s%0d", tag, d, s), {7'b0, dp},
                         {7'b0, !(d == 2 && s != 0)});
                if (chg && d == 1 && s == 1)
                    rd_data = chg_data;
            end
        end
    endtask

    int unsigned low_cnt [4];
    int unsigned multi_low;

    initial begin
        rst_n      = 1'b0;
        addr       = 8'h00;
        rd_data    = 8'h00;
        write_mode = 1'b0;

        repeat (3) begin
            @(posedge clk); #1;
            check_eq("rst_an",  {4'b0, an},  8'h0F);
            check_eq("rst_seg", {1'b0, seg}, 8'h7F);
            check_eq("rst_dp",  {7'b0, dp},  8'h01);
        end

        // New inputs present before release must not appear until the first wrap.
        addr    = 8'h3C;
        rd_data = 8'hA5;
        @(negedge clk) rst_n = 1'b1;
        run_scan("first", 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000, 1'b0, 8'h00);

        write_mode = 1'b1;
        addr       = 8'hFF;
        run_scan("disp", 7'b0010010, 7'b0001000, 7'b1000110, 7'b0110000, 1'b0, 8'h00);

        write_mode = 1'b0;
        addr       = 8'h00;
        rd_data    = 8'h11;
        run_scan("wm", 7'b0111111, 7'b0111111, 7'b0001110, 7'b0001110, 1'b0, 8'h00);

        run_scan("snap1", 7'b1111001, 7'b1111001, 7'b1000000, 7'b1000000, 1'b1, 8'h22);
        run_scan("snap2", 7'b0100100, 7'b0100100, 7'b1000000, 7'b1000000, 1'b0, 8'h00);

        repeat (10) @(posedge clk);
        #1;
        check_eq("pre_rst_an", {4'b0, an}, 8'h0B);
        check_eq("pre_rst_dp", {7'b0, dp}, 8'h00);
        #2 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_an",  {4'b0, an},  8'h0F);
        check_eq("mid_rst_seg", {1'b0, seg}, 8'h7F);
        check_eq("mid_rst_dp",  {7'b0, dp},  8'h01);
        @(posedge clk); #1;
        check_eq("mid_rst_an2", {4'b0, an}, 8'h0F);
        @(negedge clk) rst_n = 1'b1;
        run_scan("post_rst", 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000, 1'b0, 8'h00);

        for (int i = 0; i < 4; i++) low_cnt[i] = 0;
        multi_low = 0;
        repeat (64) begin
            int unsigned lows;
            @(posedge clk); #1;
            lows = 0;
            for (int i = 0; i < 4; i++) begin
                if (an[i] == 1'b0) begin
                    low_cnt[i]++;
                    lows++;
                end
            end
            if (lows > 1) multi_low++;
        end
        for (int i = 0; i < 4; i++)
            check_eq($sformatf("cadence_an%0d", i), 8'(low_cnt[i]), 8'd12);
        check_eq("cadence_multi", 8'(multi_low), 8'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
